// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the unified-memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_WAIT} arb_state_t;
    typedef enum logic {OWN_I, OWN_D} arb_owner_t;

    localparam logic [3:0] BE_WORD = 4'hF;

    // A full-word access must be word aligned; partial-lane accesses may sit anywhere.
    function automatic logic word_misaligned(input logic [31:0] addr, input logic [3:0] be);
        return (addr[1:0] != 2'b00) && (be == BE_WORD);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory handshakes around the arbiter.
interface mem_port_arbiter_if;

    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;

    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;

    logic        m_req;
    logic        m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_gnt;
    logic        m_rvalid;
    logic [31:0] m_rdata;

    logic        err;

    // Arbiter view: requests and memory responses come in, grants and memory commands go out.
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, m_gnt, m_rvalid, m_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        output m_req, m_we, m_be, m_addr, m_wdata, err
    );

    // Environment view: core requesters plus the memory device.
    modport master (
        output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, m_gnt, m_rvalid, m_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        input  m_req, m_we, m_be, m_addr, m_wdata, err
    );

endinterface

// File: rtl/arb_starve_ctr.sv
// Saturating count of fetch-side arbitration losses; forces a fetch win at the limit.
module arb_starve_ctr #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic force_i
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] count;

    // Clear wins over increment; hold at the limit until the fetch side is served.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    assign force_i = (count >= LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch (I) and load/store (D),
// one transaction outstanding at a time.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus
);

    arb_state_t  state;
    arb_state_t  state_next;
    arb_owner_t  owner;
    logic [31:2] lat_addr;
    logic        lat_we;
    logic [3:0]  lat_be;
    logic [31:0] lat_wdata;
    logic        grant_i;
    logic        grant_d;
    logic        force_i;
    logic        err_set;
    logic        err_q;

    arb_starve_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
        .clk     (clk),
        .reset   (reset),
        .inc     (grant_d && bus.i_req),
        .clr     (grant_i),
        .force_i (force_i)
    );

    // Arbitrate only in IDLE: D has priority unless the fetch side has starved too long.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state == ARB_IDLE) begin
            if (bus.d_req && !(bus.i_req && force_i)) begin
                grant_d = 1'b1;
            end else if (bus.i_req) begin
                grant_i = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: IDLE grants, REQ waits for address acceptance, WAIT waits for the response.
    always_comb begin
        state_next = state;
        case (state)
            ARB_IDLE: if (grant_i || grant_d) state_next = ARB_REQ;
            ARB_REQ:  if (bus.m_gnt)          state_next = ARB_WAIT;
            ARB_WAIT: if (bus.m_rvalid)       state_next = ARB_IDLE;
            default:                          state_next = ARB_IDLE;
        endcase
    end

    // Capture the winner's request so the requester may drop it right after the grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner     <= OWN_I;
            lat_addr  <= '0;
            lat_we    <= 1'b0;
            lat_be    <= '0;
            lat_wdata <= '0;
        end else if (grant_d) begin
            owner     <= OWN_D;
            lat_addr  <= bus.d_addr[31:2];
            lat_we    <= bus.d_we;
            lat_be    <= bus.d_be;
            lat_wdata <= bus.d_wdata;
        end else if (grant_i) begin
            owner     <= OWN_I;
            lat_addr  <= bus.i_addr[31:2];
            lat_we    <= 1'b0;
            lat_be    <= BE_WORD;
            lat_wdata <= '0;
        end
    end

    // Protocol violations are only flagged; they never steer the FSM.
    assign err_set = (bus.m_rvalid && (state != ARB_WAIT))
                   || (bus.m_gnt && (state != ARB_REQ))
                   || (grant_i && word_misaligned(bus.i_addr, BE_WORD))
                   || (grant_d && word_misaligned(bus.d_addr, bus.d_be));

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end

    assign bus.i_gnt    = grant_i;
    assign bus.d_gnt    = grant_d;
    assign bus.m_req    = (state == ARB_REQ);
    assign bus.m_addr   = {lat_addr, 2'b00};
    assign bus.m_we     = lat_we;
    assign bus.m_be     = lat_be;
    assign bus.m_wdata  = lat_wdata;
    assign bus.i_rvalid = (state == ARB_WAIT) && bus.m_rvalid && (owner == OWN_I);
    assign bus.d_rvalid = (state == ARB_WAIT) && bus.m_rvalid && (owner == OWN_D);
    assign bus.i_rdata  = bus.m_rdata;
    assign bus.d_rdata  = bus.m_rdata;
    assign bus.err      = err_q;

endmodule
